// File: rtl/mont_pkg.sv
// Shared types for the Montgomery modular-exponentiation controller.
package mont_pkg;

  localparam int unsigned DefaultWidth    = 512;
  localparam int unsigned DefaultExpWidth = 512;

  typedef enum logic [3:0] {
    StIdle,
    StLoad,
    StToMont,
    StSkip,
    StSquare,
    StMult,
    StNext,
    StFromMont,
    StWait,
    StDone
  } state_e;

  // Remembers which multiplication is in flight so WAIT knows where to return.
  typedef enum logic [1:0] {
    OpToMont,
    OpSq,
    OpMul,
    OpFrom
  } op_e;

  function automatic logic is_issue(state_e s);
    return s inside {StToMont, StSquare, StMult, StFromMont};
  endfunction

endpackage

// File: rtl/exp_scanner.sv
// Exponent bit scanner: walks E from the top bit down, one bit per dec.
module exp_scanner
  import mont_pkg::*;
#(
  parameter int unsigned EXP_WIDTH = DefaultExpWidth,
  parameter int unsigned CNT_W     = $clog2(EXP_WIDTH + 1)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 load,
  input  logic                 dec,
  input  logic [EXP_WIDTH-1:0] in_e,
  output logic                 cur_bit,
  output logic                 is_last
);

  logic [EXP_WIDTH-1:0] e_q;
  logic [CNT_W-1:0]     idx_q;

  // E is shifted left on each dec, so the current bit always sits at the MSB.
  always_ff @(posedge clk) begin
    if (reset) begin
      e_q   <= '0;
      idx_q <= '0;
    end else if (load) begin
      e_q   <= in_e;
      idx_q <= CNT_W'(EXP_WIDTH - 1);
    end else if (dec) begin
      e_q   <= {e_q[EXP_WIDTH-2:0], 1'b0};
      idx_q <= idx_q - CNT_W'(1);
    end
  end

  assign cur_bit = e_q[EXP_WIDTH-1];
  assign is_last = (idx_q == '0);

endmodule

// File: rtl/mont_exp.sv
// Left-to-right square-and-multiply controller sequencing an external Montgomery multiplier.
module mont_exp
  import mont_pkg::*;
#(
  parameter int unsigned WIDTH     = DefaultWidth,
  parameter int unsigned EXP_WIDTH = DefaultExpWidth,
  parameter int unsigned CNT_W     = $clog2(EXP_WIDTH + 1)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [WIDTH-1:0]     in_x,
  input  logic [EXP_WIDTH-1:0] in_e,
  input  logic [WIDTH-1:0]     in_m,
  input  logic [WIDTH-1:0]     in_r,
  input  logic [WIDTH-1:0]     in_r2,
  output logic                 mm_start,
  output logic [WIDTH-1:0]     mm_a,
  output logic [WIDTH-1:0]     mm_b,
  output logic [WIDTH-1:0]     mm_m,
  input  logic [WIDTH-1:0]     mm_result,
  input  logic                 mm_done,
  output logic                 busy,
  output logic                 done,
  output logic [WIDTH-1:0]     result
);

  state_e state_q, state_d;
  op_e    op_q, op_d;

  logic [WIDTH-1:0] x_q, m_q, r_q, r2_q;
  logic [WIDTH-1:0] a_q, a_d, xt_q, xt_d, res_q, res_d;
  logic [WIDTH-1:0] mm_a_q, mm_a_d, mm_b_q, mm_b_d;
  logic             scan_load, scan_dec, cur_bit, is_last;

  exp_scanner #(
    .EXP_WIDTH(EXP_WIDTH),
    .CNT_W    (CNT_W)
  ) u_scanner (
    .clk    (clk),
    .reset  (reset),
    .load   (scan_load),
    .dec    (scan_dec),
    .in_e   (in_e),
    .cur_bit(cur_bit),
    .is_last(is_last)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      op_q    <= OpToMont;
      x_q     <= '0;
      m_q     <= '0;
      r_q     <= '0;
      r2_q    <= '0;
      a_q     <= '0;
      xt_q    <= '0;
      res_q   <= '0;
      mm_a_q  <= '0;
      mm_b_q  <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      a_q     <= a_d;
      xt_q    <= xt_d;
      res_q   <= res_d;
      mm_a_q  <= mm_a_d;
      mm_b_q  <= mm_b_d;
      if (state_q == StIdle && start) begin
        x_q  <= in_x;
        m_q  <= in_m;
        r_q  <= in_r;
        r2_q <= in_r2;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    scan_load = 1'b0;
    scan_dec  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d   = StLoad;
          scan_load = 1'b1;
        end
      end
      StLoad:   state_d = StToMont;
      StToMont: begin
        state_d = StWait;
        op_d    = OpToMont;
      end
      StSkip: begin
        if (cur_bit) begin
          state_d = StSquare;
        end else if (is_last) begin
          state_d = StFromMont;
        end else begin
          scan_dec = 1'b1;
        end
      end
      StSquare: begin
        state_d = StWait;
        op_d    = OpSq;
      end
      StMult: begin
        state_d = StWait;
        op_d    = OpMul;
      end
      StNext: begin
        if (is_last) begin
          state_d = StFromMont;
        end else begin
          scan_dec = 1'b1;
          state_d  = StSquare;
        end
      end
      StFromMont: begin
        state_d = StWait;
        op_d    = OpFrom;
      end
      StWait: begin
        // The launch pulse happens in the issue state, so any stale done is never seen here.
        if (mm_done) begin
          unique case (op_q)
            OpToMont: state_d = StSkip;
            OpSq:     state_d = cur_bit ? StMult : StNext;
            OpMul:    state_d = StNext;
            OpFrom:   state_d = StDone;
          endcase
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    a_d    = a_q;
    xt_d   = xt_q;
    res_d  = res_q;
    mm_a_d = mm_a_q;
    mm_b_d = mm_b_q;
    if (state_q == StLoad) begin
      a_d = r_q;
    end
    if (state_q == StWait && mm_done) begin
      unique case (op_q)
        OpToMont:   xt_d  = mm_result;
        OpSq, OpMul: a_d  = mm_result;
        OpFrom:     res_d = mm_result;
      endcase
    end
    // Operands are latched on entry to the issue state and held through WAIT.
    case (state_d)
      StToMont: begin
        mm_a_d = x_q;
        mm_b_d = r2_q;
      end
      StSquare: begin
        mm_a_d = a_d;
        mm_b_d = a_d;
      end
      StMult: begin
        mm_a_d = a_d;
        mm_b_d = xt_q;
      end
      StFromMont: begin
        mm_a_d = a_d;
        mm_b_d = WIDTH'(1);
      end
      default: ;
    endcase
  end

  always_comb begin
    mm_start = is_issue(state_q);
    busy     = 1'b1;
    done     = 1'b0;
    case (state_q)
      StIdle: busy = 1'b0;
      StDone: begin
        busy = 1'b0;
        done = 1'b1;
      end
      default: ;
    endcase
  end

  assign mm_a   = mm_a_q;
  assign mm_b   = mm_b_q;
  assign mm_m   = m_q;
  assign result = res_q;

endmodule

// File: tb/tb_mont_exp.sv
// Directed bench for mont_exp with a behavioural Montgomery multiplier responder.
module tb_mont_exp;

  localparam int unsigned W  = 512;
  localparam int unsigned EW = 512;

  logic          clk = 1'b0;
  logic          reset, start;
  logic [W-1:0]  in_x, in_m, in_r, in_r2;
  logic [EW-1:0] in_e;
  logic          mm_start, busy, done;
  logic [W-1:0]  mm_a, mm_b, mm_m, result;
  logic [W-1:0]  mm_result = '0;
  logic          mm_done = 1'b0;

  always #5 clk = ~clk;

  mont_exp #(
    .WIDTH    (W),
    .EXP_WIDTH(EW)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .in_x     (in_x),
    .in_e     (in_e),
    .in_m     (in_m),
    .in_r     (in_r),
    .in_r2    (in_r2),
    .mm_start (mm_start),
    .mm_a     (mm_a),
    .mm_b     (mm_b),
    .mm_m     (mm_m),
    .mm_result(mm_result),
    .mm_done  (mm_done),
    .busy     (busy),
    .done     (done),
    .result   (result)
  );

  function automatic logic [W-1:0] mont(input logic [W-1:0] a, input logic [W-1:0] b,
                                        input logic [W-1:0] m);
    logic [W+1:0] t;
    t = '0;
    for (int i = 0; i < W; i++) begin
      if (a[i]) t = t + {2'b00, b};
      if (t[0]) t = t + {2'b00, m};
      t = t >> 1;
    end
    if (t >= {2'b00, m}) t = t - {2'b00, m};
    return t[W-1:0];
  endfunction

  function automatic logic [W-1:0] pow2mod(input int unsigned n, input logic [W-1:0] m);
    logic [W+1:0] t;
    t = {{(W+1){1'b0}}, 1'b1};
    for (int i = 0; i < n; i++) begin
      t = t << 1;
      if (t >= {2'b00, m}) t = t - {2'b00, m};
    end
    return t[W-1:0];
  endfunction

  function automatic longint unsigned modpow(input longint unsigned b, input longint unsigned e,
                                             input longint unsigned m);
    longint unsigned r;
    r = 1;
    for (int i = 31; i >= 0; i--) begin
      r = (r * r) % m;
      if (e[i]) r = (r * b) % m;
    end
    return r;
  endfunction

  // Multiplier responder: D cycles from pulse to done, pulse- or level-type done.
  logic          level_mode = 1'b0;
  logic          rand_d = 1'b0;
  logic          pend = 1'b0;
  int unsigned   next_d = 5;
  int unsigned   rsp_cnt = 0;
  logic [W-1:0]  lat_a = '0, lat_b = '0, rsp_res = '0;
  int unsigned   n_start = 0, n_done = 0, viol = 0;
  longint        cyc = 0;

  always @(posedge clk) begin
    cyc    <= cyc + 1;
    n_done <= n_done + (done ? 1 : 0);
    if (reset) begin
      pend <= 1'b0;
    end else if (mm_start) begin
      n_start <= n_start + 1;
      lat_a   <= mm_a;
      lat_b   <= mm_b;
      rsp_res <= mont(mm_a, mm_b, mm_m);
      next_d  <= rand_d ? $urandom_range(40, 1) : 5;
      if (next_d == 1) begin
        mm_done   <= 1'b1;
        mm_result <= mont(mm_a, mm_b, mm_m);
        pend      <= 1'b0;
      end else begin
        mm_done   <= 1'b0;
        mm_result <= {16{32'hdeadbeef}};
        rsp_cnt   <= next_d - 1;
        pend      <= 1'b1;
      end
    end else if (pend) begin
      if (mm_a !== lat_a || mm_b !== lat_b) viol <= viol + 1;
      if (rsp_cnt == 1) begin
        mm_done   <= 1'b1;
        mm_result <= rsp_res;
        pend      <= 1'b0;
      end else begin
        rsp_cnt <= rsp_cnt - 1;
      end
    end else if (!level_mode) begin
      mm_done <= 1'b0;
    end
  end

  int unsigned n_chk = 0, n_pass = 0, n_fail = 0;
  int unsigned s0, d0;
  longint      t0, lat;

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
    end
  endtask

  task automatic start_op(input logic [W-1:0] x, input logic [EW-1:0] e,
                          input logic [W-1:0] m, input logic hammer);
    in_x  = x;
    in_e  = e;
    in_m  = m;
    in_r  = pow2mod(W, m);
    in_r2 = pow2mod(2 * W, m);
    s0    = n_start;
    d0    = n_done;
    t0    = cyc;
    start = 1'b1;
    @(posedge clk); #1;
    start = hammer;
    if (hammer) begin
      in_x = W'(5);
      in_e = EW'(1);
    end
    check("busy_cycle1", W'(busy), W'(1));
    check("no_pulse_cycle1", W'(mm_start), W'(0));
    @(posedge clk); #1;
    check("first_pulse_cycle2", W'(mm_start), W'(1));
  endtask

  task automatic wait_done(input logic hammer);
    int unsigned k;
    k = 0;
    while (!done && k < 20000) begin
      @(posedge clk); #1;
      k++;
      start = hammer;
    end
    start = 1'b0;
    lat   = cyc - t0;
    check("done_seen", W'(done), W'(1));
    check("busy_low_at_done", W'(busy), W'(0));
    @(posedge clk); #1;
    check("done_one_cycle", W'(done), W'(0));
  endtask

  initial begin
    logic [W-1:0] big_m;
    int unsigned  k;
    reset = 1'b1;
    start = 1'b0;
    in_x  = '0;
    in_e  = '0;
    in_m  = '0;
    in_r  = '0;
    in_r2 = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", W'(busy), W'(0));
    check("rst_done", W'(done), W'(0));
    check("rst_mm_start", W'(mm_start), W'(0));
    check("rst_result", result, W'(0));
    reset = 1'b0;
    @(posedge clk); #1;

    // 4^13 mod 497 = 445, 2 + 4 + 3 multiplications
    start_op(W'(4), EW'(13), W'(497), 1'b0);
    wait_done(1'b0);
    check("t1_result", result, W'(445));
    check("t1_latency", W'(lat), W'(569));
    check("t1_pulses", W'(n_start - s0), W'(9));
    repeat (3) @(posedge clk);
    #1;
    check("t1_done_count", W'(n_done - d0), W'(1));
    check("t1_result_held", result, W'(445));

    // E = 0: only the to/from conversions
    start_op(W'(7), EW'(0), W'(11), 1'b0);
    wait_done(1'b0);
    check("t2_result", result, W'(1));
    check("t2_latency", W'(lat), W'(526));
    check("t2_pulses", W'(n_start - s0), W'(2));

    // E = 1 with a full-width modulus
    big_m      = '0;
    big_m[W-1] = 1'b1;
    big_m      = big_m + W'(111);
    start_op(W'(123456789), EW'(1), big_m, 1'b0);
    wait_done(1'b0);
    check("t3_result", result, W'(123456789));
    check("t3_pulses", W'(n_start - s0), W'(4));

    // Random latency, level-type done held over from the previous operation
    level_mode = 1'b1;
    rand_d     = 1'b1;
    start_op(W'(3), EW'(65537), W'(1000003), 1'b0);
    wait_done(1'b0);
    check("t4_result", result, W'(modpow(3, 65537, 1000003)));
    check("t4_pulses", W'(n_start - s0), W'(21));
    repeat (3) @(posedge clk);
    #1;
    check("t4_done_count", W'(n_done - d0), W'(1));
    level_mode = 1'b0;
    rand_d     = 1'b0;
    repeat (45) @(posedge clk);
    #1;

    // Reset at the third launch, then a clean rerun
    start_op(W'(4), EW'(13), W'(497), 1'b0);
    k = 0;
    while (!(mm_start && (n_start - s0) == 2) && k < 5000) begin
      @(posedge clk); #1;
      k++;
    end
    check("t5_third_pulse_seen", W'(mm_start), W'(1));
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("t5_busy_after_reset", W'(busy), W'(0));
    check("t5_mm_start_after_reset", W'(mm_start), W'(0));
    check("t5_result_after_reset", result, W'(0));
    repeat (8) @(posedge clk);
    #1;
    start_op(W'(4), EW'(13), W'(497), 1'b0);
    wait_done(1'b0);
    check("t5_result", result, W'(445));
    check("t5_pulses", W'(n_start - s0), W'(9));

    // start held high throughout with different operands presented
    start_op(W'(4), EW'(13), W'(497), 1'b1);
    wait_done(1'b1);
    check("t6_result", result, W'(445));
    check("t6_pulses", W'(n_start - s0), W'(9));
    repeat (3) @(posedge clk);
    #1;
    check("t6_done_count", W'(n_done - d0), W'(1));
    check("t6_idle_after", W'(busy), W'(0));
    check("t6_result_held", result, W'(445));

    check("operand_hold", W'(viol), W'(0));
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
